// File: rtl/apb_slave_mem.sv
// APB3 completer with a word-addressed memory and a fixed number of wait states per access.
// Define APB_SLV_PSTRB_EN to add the APB4 byte-strobe input pstrb for partial writes.
module apb_slave_mem #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0]        WAIT_LD = 4'(WAIT_CYCLES);

  if (DATA_W != 32) begin : g_chk_data_w
    $error("apb_slave_mem: DATA_W must be 32");
  end
  if (DEPTH < 2 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("apb_slave_mem: DEPTH must be a power of two in 2..4096");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_chk_wait
    $error("apb_slave_mem: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {IDLE_ST, WAIT_ST, RESP_ST} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_write, r_err;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_pready, r_pslverr;
  logic [DATA_W-1:0]   r_prdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W:0]     w_diff;
  logic [ADDR_W-1:0]   w_off;
  logic                w_err_now;
  logic [IDX_W-1:0]    w_idx_now;
  logic                w_setup, w_commit;
  logic                w_xfer_write, w_xfer_err;
  logic [IDX_W-1:0]    w_xfer_idx;
  logic [DATA_W-1:0]   w_wmask;

  // Extra top bit of the difference is the borrow: an address below BASE_ADDR errors instead of wrapping.
  always_comb begin
    w_diff    = {1'b0, paddr} - {1'b0, BASE_ADDR};
    w_off     = w_diff[ADDR_W-1:0];
    w_err_now = (paddr[1:0] != 2'b00) || w_diff[ADDR_W] || ((w_off >> 2) >= DEPTH_A);
    w_idx_now = w_off[IDX_W+1:2];
    w_setup   = (r_state == IDLE_ST) && psel && !penable;
    w_commit  = r_pready && psel && penable && r_write && !r_err;
  end

  // With zero wait states the response is launched straight from the setup cycle, before the latches load.
  always_comb begin
    w_xfer_write = r_write;
    w_xfer_err   = r_err;
    w_xfer_idx   = r_idx;
    if (r_state == IDLE_ST) begin
      w_xfer_write = pwrite;
      w_xfer_err   = w_err_now;
      w_xfer_idx   = w_idx_now;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE_ST: if (w_setup) w_next = (WAIT_CYCLES > 0) ? WAIT_ST : RESP_ST;
      WAIT_ST: begin
        if (!psel)               w_next = IDLE_ST;
        else if (r_cnt == 4'd1)  w_next = RESP_ST;
      end
      RESP_ST: w_next = IDLE_ST;
      default: w_next = IDLE_ST;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state <= IDLE_ST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_setup)                  r_cnt <= WAIT_LD;
      else if (r_state == WAIT_ST)  r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_setup) begin
      r_write <= pwrite;
      r_err   <= w_err_now;
      r_idx   <= w_idx_now;
      r_wdata <= pwdata;
    end
  end

`ifdef APB_SLV_PSTRB_EN
  logic [DATA_W/8-1:0] r_strb;

  always_ff @(posedge pclk) begin
    if (!presetn)     r_strb <= '0;
    else if (w_setup) r_strb <= pstrb;
  end

  for (genvar g = 0; g < DATA_W/8; g++) begin : g_wmask
    assign w_wmask[8*g +: 8] = {8{r_strb[g]}};
  end
`else
  assign w_wmask = '1;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= (w_next == RESP_ST);
      r_pslverr <= (w_next == RESP_ST) && w_xfer_err;
      if ((w_next == RESP_ST) && !w_xfer_write)
        r_prdata <= w_xfer_err ? '0 : r_mem[w_xfer_idx];
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn)      r_mem <= '{default: '0};
    else if (w_commit) r_mem[r_idx] <= (r_mem[r_idx] & ~w_wmask) | (r_wdata & w_wmask);
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem: three instances (1, 0 and 15 wait states) against a memory model.
// Build with APB_SLV_PSTRB_EN defined to also exercise byte strobes.
module tb_apb_slave_mem;

  localparam int DEPTH = 256;

  logic        pclk = 1'b0;
  logic        presetn, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  psel_v, pready_v, pslverr_v;
  logic [31:0] prdata_v0, prdata_v1, prdata_v2;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [3][DEPTH];
  logic [31:0] last_rd [3];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready_v[0]), .prdata(prdata_v0), .pslverr(pslverr_v[0]));

  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0)) dut_w0 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready_v[1]), .prdata(prdata_v1), .pslverr(pslverr_v[1]));

  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(15)) dut_w15 (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb),
`endif
    .pready(pready_v[2]), .prdata(prdata_v2), .pslverr(pslverr_v[2]));

  function automatic logic [31:0] base_of(input logic [1:0] d);
    return (d == 2'd1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic int wait_of(input logic [1:0] d);
    case (d)
      2'd0:    return 1;
      2'd1:    return 0;
      default: return 15;
    endcase
  endfunction

  function automatic logic ready_of(input logic [1:0] d);
    case (d)
      2'd0:    return pready_v[0];
      2'd1:    return pready_v[1];
      default: return pready_v[2];
    endcase
  endfunction

  function automatic logic err_of(input logic [1:0] d);
    case (d)
      2'd0:    return pslverr_v[0];
      2'd1:    return pslverr_v[1];
      default: return pslverr_v[2];
    endcase
  endfunction

  function automatic logic [31:0] rd_of(input logic [1:0] d);
    case (d)
      2'd0:    return prdata_v0;
      2'd1:    return prdata_v1;
      default: return prdata_v2;
    endcase
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
    end
  endfunction

  // Expected response of one completed transfer; writes update the model, reads remember prdata.
  function automatic void model(input logic [1:0] d, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                output logic [31:0] exp_rd, output logic exp_err);
    longint unsigned a, b;
    int idx;
    a = addr;
    b = base_of(d);
    exp_err = (a % 4 != 0) || (a < b) || ((a - b) / 4 >= DEPTH);
    idx = exp_err ? 0 : int'((a - b) / 4);
    if (!wr) begin
      exp_rd = exp_err ? 32'h0 : ref_mem[d][idx];
      last_rd[d] = exp_rd;
    end else begin
      exp_rd = last_rd[d];
      if (!exp_err) begin
`ifdef APB_SLV_PSTRB_EN
        for (int k = 0; k < 4; k++)
          if (strb[k]) ref_mem[d][idx][8*k +: 8] = wdata[8*k +: 8];
`else
        ref_mem[d][idx] = wdata;
`endif
      end
    end
  endfunction

  // Full APB transfer; lat = number of access cycles up to and including the pready cycle.
  task automatic xfer(input logic [1:0] d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    lat = 0; rdata = '0; err = 1'b0; n = 0;
    psel_v = 3'b001 << d; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (lat == 0 && n < 40) begin
      n++;
      paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
      @(negedge pclk);
      if (ready_of(d)) begin
        lat = n; rdata = rd_of(d); err = err_of(d);
      end
      @(posedge pclk); #1;
    end
    psel_v = '0; penable = 1'b0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: dut=%0d addr=%h got no pready, required within 40 cycles", d, addr);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat;
    presetn = 1'b0; psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready_of(2'(i)), err_of(2'(i)), rd_of(2'(i))} !== 34'b0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d: pready=%b pslverr=%b prdata=%h, required 0/0/0",
                 i, ready_of(2'(i)), err_of(2'(i)), rd_of(2'(i)));
      end
    end
    model_clear();
    @(posedge pclk); #1;
    presetn = 1'b1;
    model(2'd0, 1'b0, 32'h10, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h10, '0, 4'hF, rd, err, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL reset_read_lat: got %0d, required 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h, required 0", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_read_err: got %b, required 0", err); end
  endtask

  task automatic test_write_readback();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat;
    model(2'd0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, err, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d, required 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b, required 0", err); end
    model(2'd0, 1'b0, 32'h4, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h4, '0, 4'hF, rd, err, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_lat: got %0d, required 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h, required deadbeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, exp_rd, v; logic err, exp_err; int lat;
    v = $urandom | 32'h1;
    model(2'd0, 1'b1, 32'h3FC, v, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h3FC, v, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL top_word_wr_err: got %b, required 0", err); end
    model(2'd0, 1'b0, 32'h402, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h402, '0, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b, required 1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_data: got %h, required 0", rd); end
    model(2'd0, 1'b1, 32'h400, 32'hCAFE0000, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h400, 32'hCAFE0000, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_write_err: got %b, required 1", err); end
    model(2'd0, 1'b0, 32'h3FC, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h3FC, '0, 4'hF, rd, err, lat);
    checks++; if (rd !== v) begin errors++; $display("FAIL top_word_unchanged: got %h, required %h", rd, v); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL top_word_rd_err: got %b, required 0", err); end
    model(2'd1, 1'b0, 32'hFFC, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd1, 1'b0, 32'hFFC, '0, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b, required 1", err); end
    model(2'd1, 1'b0, 32'h13FC, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd1, 1'b0, 32'h13FC, '0, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL base_top_err: got %b, required 0", err); end
    model(2'd1, 1'b0, 32'h1400, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd1, 1'b0, 32'h1400, '0, 4'hF, rd, err, lat);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL base_oob_err: got %b, required 1", err); end
  endtask

  task automatic test_wait_sweep();
    logic [31:0] rd, exp_rd, v; logic err, exp_err; int lat;
    for (int i = 1; i < 3; i++) begin
      v = $urandom;
      model(2'(i), 1'b1, base_of(2'(i)) + 32'h40, v, 4'hF, exp_rd, exp_err);
      xfer(2'(i), 1'b1, base_of(2'(i)) + 32'h40, v, 4'hF, rd, err, lat);
      checks++; if (lat !== wait_of(2'(i)) + 1) begin errors++; $display("FAIL sweep_wr_lat dut=%0d: got %0d, required %0d", i, lat, wait_of(2'(i)) + 1); end
      model(2'(i), 1'b0, base_of(2'(i)) + 32'h40, '0, 4'hF, exp_rd, exp_err);
      xfer(2'(i), 1'b0, base_of(2'(i)) + 32'h40, '0, 4'hF, rd, err, lat);
      checks++; if (lat !== wait_of(2'(i)) + 1) begin errors++; $display("FAIL sweep_rd_lat dut=%0d: got %0d, required %0d", i, lat, wait_of(2'(i)) + 1); end
      checks++; if (rd !== v) begin errors++; $display("FAIL sweep_rd_data dut=%0d: got %h, required %h", i, rd, v); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp_rd, v, a; logic err, exp_err; int lat;
    model(2'd0, 1'b1, 32'h0, 32'h11, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h0, 32'h11, 4'hF, rd, err, lat);
    model(2'd0, 1'b0, 32'h0, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h0, '0, 4'hF, rd, err, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_lat: got %0d, required 2", lat); end
    checks++; if (rd !== 32'h11) begin errors++; $display("FAIL b2b_data: got %h, required 00000011", rd); end
    @(negedge pclk);
    checks++; if (pready_v[0] !== 1'b0) begin errors++; $display("FAIL pready_one_cycle: got %b, required 0", pready_v[0]); end
    @(posedge pclk); #1;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      a = base_of(2'd1) + 4 * $urandom_range(0, DEPTH - 1);
      model(2'd1, 1'b1, a, v, 4'hF, exp_rd, exp_err);
      xfer(2'd1, 1'b1, a, v, 4'hF, rd, err, lat);
      model(2'd1, 1'b0, a, '0, 4'hF, exp_rd, exp_err);
      xfer(2'd1, 1'b0, a, '0, 4'hF, rd, err, lat);
      checks++; if (lat !== 1 || rd !== exp_rd) begin errors++; $display("FAIL b2b_w0 addr=%h: got lat %0d data %h, required lat 1 data %h", a, lat, rd, exp_rd); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat, seen;
    for (int i = 0; i < 3; i += 2) begin
      model(2'(i), 1'b1, 32'h8, 32'h77 + i, 4'hF, exp_rd, exp_err);
      xfer(2'(i), 1'b1, 32'h8, 32'h77 + i, 4'hF, rd, err, lat);
      psel_v = 3'b001 << i; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h22; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      repeat ((i == 0) ? 0 : 5) begin @(posedge pclk); #1; end
      psel_v = '0; penable = 1'b0;
      seen = 0;
      repeat (20) begin
        @(negedge pclk);
        if (ready_of(2'(i))) seen++;
      end
      @(posedge pclk); #1;
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_pready dut=%0d: got %0d pready cycles, required 0", i, seen); end
      model(2'(i), 1'b0, 32'h8, '0, 4'hF, exp_rd, exp_err);
      xfer(2'(i), 1'b0, 32'h8, '0, 4'hF, rd, err, lat);
      checks++; if (rd !== 32'h77 + i) begin errors++; $display("FAIL abort_mem dut=%0d: got %h, required %h", i, rd, 32'h77 + i); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat, seen;
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hABCD; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    repeat (3) begin @(posedge pclk); #1; end
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1; psel_v = '0; penable = 1'b0;
    model_clear();
    @(negedge pclk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready_of(2'(i)), err_of(2'(i)), rd_of(2'(i))} !== 34'b0) begin
        errors++;
        $display("FAIL midreset_outputs dut=%0d: pready=%b pslverr=%b prdata=%h, required 0/0/0",
                 i, ready_of(2'(i)), err_of(2'(i)), rd_of(2'(i)));
      end
    end
    seen = 0;
    repeat (20) begin @(negedge pclk); if (pready_v[2]) seen++; end
    @(posedge pclk); #1;
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_pready: got %0d pready cycles, required 0", seen); end
    model(2'd2, 1'b0, 32'h20, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd2, 1'b0, 32'h20, '0, 4'hF, rd, err, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_nowrite: got %h, required 0", rd); end
    model(2'd0, 1'b0, 32'h4, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h4, '0, 4'hF, rd, err, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL midreset_memclear: got %h, required 0", rd); end
  endtask

  task automatic test_random();
    logic [1:0] d; logic wr, err, exp_err; logic [31:0] a, wd, rd, exp_rd; logic [3:0] st; int lat, cat;
    for (int i = 0; i < 80; i++) begin
      d   = 2'($urandom_range(0, 2));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      st  = 4'($urandom);
      cat = $urandom_range(0, 9);
      if (cat <= 3)      a = base_of(d) + 4 * $urandom_range(0, 15);
      else if (cat <= 6) a = base_of(d) + 4 * $urandom_range(0, DEPTH - 1);
      else if (cat == 7) a = base_of(d) + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (cat == 8) a = base_of(d) + 4 * DEPTH + 4 * $urandom_range(0, 255);
      else               a = $urandom;
      model(d, wr, a, wd, st, exp_rd, exp_err);
      xfer(d, wr, a, wd, st, rd, err, lat);
      checks++; if (lat !== wait_of(d) + 1) begin errors++; $display("FAIL rand_lat #%0d dut=%0d: got %0d, required %0d", i, d, lat, wait_of(d) + 1); end
      checks++; if (err !== exp_err) begin errors++; $display("FAIL rand_err #%0d dut=%0d addr=%h: got %b, required %b", i, d, a, err, exp_err); end
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_data #%0d dut=%0d addr=%h wr=%b: got %h, required %h", i, d, a, wr, rd, exp_rd); end
    end
  endtask

`ifdef APB_SLV_PSTRB_EN
  task automatic test_pstrb();
    logic [31:0] rd, exp_rd; logic err, exp_err; int lat;
    model(2'd0, 1'b1, 32'h0, 32'hAABBCCDD, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h0, 32'hAABBCCDD, 4'hF, rd, err, lat);
    model(2'd0, 1'b1, 32'h0, 32'h11223344, 4'b0101, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h0, 32'h11223344, 4'b0101, rd, err, lat);
    model(2'd0, 1'b1, 32'h0, 32'h99999999, 4'b0000, exp_rd, exp_err);
    xfer(2'd0, 1'b1, 32'h0, 32'h99999999, 4'b0000, rd, err, lat);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pstrb_zero_err: got %b, required 0", err); end
    model(2'd0, 1'b0, 32'h0, '0, 4'hF, exp_rd, exp_err);
    xfer(2'd0, 1'b0, 32'h0, '0, 4'hF, rd, err, lat);
    checks++; if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL pstrb_merge: got %h, required aa22cc44", rd); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_readback();
    test_errors();
    test_wait_sweep();
    test_back_to_back();
    test_abort();
`ifdef APB_SLV_PSTRB_EN
    test_pstrb();
`endif
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
